// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The master is the pipeline side; the slave is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_useRt;
    logic [4:0]       EX_Rt;
    logic             EX_MemRd;
    logic             EX_taken;
    logic             MEM_MemRd;
    logic             MEM_MemWr;
    logic             mem_ready;
    logic             PC_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             IDEX_write;
    logic             IDEX_flush;
    logic             EXMEM_write;
    logic             MEMWB_flush;
    logic             mem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ID_Rs, ID_Rt, ID_useRt, EX_Rt, EX_MemRd, EX_taken,
               MEM_MemRd, MEM_MemWr, mem_ready,
        input  PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush,
               EXMEM_write, MEMWB_flush, mem_req, mem_err, stall_cnt
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_useRt, EX_Rt, EX_MemRd, EX_taken,
               MEM_MemRd, MEM_MemWr, mem_ready,
        output PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush,
               EXMEM_write, MEMWB_flush, mem_req, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and whole-pipe freeze while a MEM-stage access waits on mem_ready.
//
// state | meaning
// IDLE  | no outstanding memory wait
// WAIT  | MEM access pending, counting cycles toward timeout
// ERR   | access timed out; pipe frozen until reset
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input logic                  clk,
    input logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              mem_err_q;

    logic mem_acc, freeze, lu;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, memwb_flush, mem_req;

    assign mem_acc = hz.MEM_MemRd | hz.MEM_MemWr;
    assign freeze  = (mem_acc & ~hz.mem_ready) | (state_q == S_ERR);
    assign lu      = hz.EX_MemRd & (hz.EX_Rt != 5'd0) &
                     ((hz.EX_Rt == hz.ID_Rs) | (hz.ID_useRt & (hz.EX_Rt == hz.ID_Rt)));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (mem_acc && !hz.mem_ready) begin
                    state_d = S_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            S_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = S_IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                    state_d = S_ERR;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: state_d = S_ERR;
        endcase
    end

    // Reset forces a safe drain; otherwise freeze > taken > load-use > normal.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        memwb_flush = 1'b0;
        mem_req     = reset & mem_acc & (state_q != S_ERR);
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
        end else if (hz.EX_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_d == S_ERR)
                mem_err_q <= 1'b1;
            if (!pc_write && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign hz.PC_write    = pc_write;
    assign hz.IFID_write  = ifid_write;
    assign hz.IFID_flush  = ifid_flush;
    assign hz.IDEX_write  = idex_write;
    assign hz.IDEX_flush  = idex_flush;
    assign hz.EXMEM_write = exmem_write;
    assign hz.MEMWB_flush = memwb_flush;
    assign hz.mem_req     = mem_req;
    assign hz.mem_err     = mem_err_q;
    assign hz.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed check of pipeline_hazard_ctrl with MEM_TIMEOUT=4, CNT_W=4.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;

    // Output vector order: PC_w IFID_w IFID_f IDEX_w IDEX_f EXMEM_w MEMWB_f mem_req
    localparam logic [7:0] O_NORM  = 8'b11010100;
    localparam logic [7:0] O_NORMQ = 8'b11010101;
    localparam logic [7:0] O_RST   = 8'b00101010;
    localparam logic [7:0] O_LU    = 8'b00011100;
    localparam logic [7:0] O_TAKEN = 8'b11111100;
    localparam logic [7:0] O_TAKEQ = 8'b11111101;
    localparam logic [7:0] O_FRZQ  = 8'b00000011;
    localparam logic [7:0] O_ERR   = 8'b00000010;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] outv;
    assign outv = {hz.PC_write, hz.IFID_write, hz.IFID_flush, hz.IDEX_write,
                   hz.IDEX_flush, hz.EXMEM_write, hz.MEMWB_flush, hz.mem_req};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                          input logic [4:0] ex_rt, input logic ex_rd, input logic taken,
                          input logic mrd, input logic mwr, input logic rdy);
        hz.ID_Rs     = rs;
        hz.ID_Rt     = rt;
        hz.ID_useRt  = use_rt;
        hz.EX_Rt     = ex_rt;
        hz.EX_MemRd  = ex_rd;
        hz.EX_taken  = taken;
        hz.MEM_MemRd = mrd;
        hz.MEM_MemWr = mwr;
        hz.mem_ready = rdy;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_outs", outv, O_RST);
        tick();
        chk("reset_cnt", hz.stall_cnt, 0);
        chk("reset_err", hz.mem_err, 0);

        reset = 1'b1;
        set_in(1, 2, 1, 3, 0, 0, 0, 0, 0);
        chk("normal", outv, O_NORM);
        tick();
        chk("normal_cnt", hz.stall_cnt, 0);

        // load-use on rs: one-cycle stall, bubble then clears EX_MemRd
        set_in(5, 7, 0, 5, 1, 0, 0, 0, 0);
        chk("lu_rs", outv, O_LU);
        tick();
        chk("lu_rs_cnt", hz.stall_cnt, 1);
        set_in(5, 7, 0, 5, 0, 0, 0, 0, 0);
        chk("lu_after", outv, O_NORM);
        tick();

        set_in(0, 0, 1, 0, 1, 0, 0, 0, 0);
        chk("lu_r0", outv, O_NORM);
        set_in(3, 5, 0, 5, 1, 0, 0, 0, 0);
        chk("lu_rt_unused", outv, O_NORM);
        set_in(3, 5, 1, 5, 1, 0, 0, 0, 0);
        chk("lu_rt_used", outv, O_LU);
        tick();
        chk("lu_rt_cnt", hz.stall_cnt, 2);

        set_in(5, 0, 0, 5, 1, 1, 0, 0, 0);
        chk("taken_over_lu", outv, O_TAKEN);
        tick();
        chk("taken_cnt", hz.stall_cnt, 2);

        set_in(1, 2, 0, 3, 0, 0, 1, 0, 1);
        chk("zero_wait", outv, O_NORMQ);
        tick();
        chk("zero_wait_cnt", hz.stall_cnt, 2);

        // 3-cycle freeze with a pending taken branch held in EX
        for (int i = 0; i < 3; i++) begin
            set_in(1, 2, 0, 3, 0, 1, 1, 0, 0);
            chk("freeze", outv, O_FRZQ);
            tick();
        end
        chk("freeze_cnt", hz.stall_cnt, 5);
        set_in(1, 2, 0, 3, 0, 1, 1, 0, 1);
        chk("freeze_release", outv, O_TAKEQ);
        tick();
        chk("release_cnt", hz.stall_cnt, 5);
        set_in(1, 2, 0, 3, 0, 0, 0, 0, 0);
        chk("idle_again", outv, O_NORM);
        tick();

        // timeout: IDLE cycle + 4 WAIT cycles, then ERR
        for (int i = 0; i < 1 + TO; i++) begin
            set_in(1, 2, 0, 3, 0, 0, 0, 1, 0);
            chk("wait_frz", outv, O_FRZQ);
            chk("wait_err", hz.mem_err, 0);
            tick();
        end
        chk("err_flag", hz.mem_err, 1);
        chk("err_cnt", hz.stall_cnt, 10);
        set_in(1, 2, 0, 3, 0, 1, 0, 1, 1);
        chk("err_outs", outv, O_ERR);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("sat_cnt", hz.stall_cnt, (11 + i > 15) ? 15 : 11 + i);
        end
        chk("err_sticky", hz.mem_err, 1);

        reset = 1'b0;
        #1;
        chk("reset_err_outs", outv, O_RST);
        tick();
        chk("rst_clr_err", hz.mem_err, 0);
        chk("rst_clr_cnt", hz.stall_cnt, 0);
        reset = 1'b1;
        set_in(1, 2, 0, 3, 0, 0, 0, 0, 0);
        chk("post_reset", outv, O_NORM);
        set_in(1, 2, 0, 3, 0, 0, 1, 0, 1);
        chk("post_reset_req", outv, O_NORMQ);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
